// File: rtl/divider_8_bit.sv
// divider_8_bit: sequential restoring divider that produces one quotient bit per clock.
// Optional macro DIVIDER_ZERO_DETECT_EN: divisor==0 skips the iterations and raises div_zero.
module divider_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH:0]   par_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   par_d;
  logic [WIDTH-1:0] num_d;
  logic             ge;
  logic             last;

  // The dividend register shifts out its MSB and takes the quotient bit in at the LSB.
  always_comb begin
    shf   = {par_q[WIDTH-1:0], num_q[WIDTH-1]};
    ge    = par_q[WIDTH] || (shf >= {1'b0, den_q});
    par_d = shf;
    num_d = {num_q[WIDTH-2:0], 1'b0};
    if (ge) begin
      par_d    = shf - {1'b0, den_q};
      num_d[0] = 1'b1;
    end
  end

  assign last = (cnt_q == 8'(WIDTH - 1));

`ifdef DIVIDER_ZERO_DETECT_EN
  logic dz_q;
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
`ifdef DIVIDER_ZERO_DETECT_EN
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
            end else begin
`else
            begin
`endif
              state_q <= RUN;
              busy_q  <= 1'b1;
              num_q   <= dividend;
              den_q   <= divisor;
              par_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          num_q <= num_d;
          par_q <= par_d;
          cnt_q <= cnt_q + 8'd1;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= num_d;
            rem_q   <= par_d[WIDTH-1:0];
`ifdef DIVIDER_ZERO_DETECT_EN
            dz_q    <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divider_8_bit.sv
// tb_divider_8_bit: directed and random operations against an integer division model.
// Expectations follow DIVIDER_ZERO_DETECT_EN when it is defined for the build.
module tb_divider_8_bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int n_chk;
  int n_err;

  divider_8_bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 gives all-ones and the dividend.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic z, output int lat, output int nbusy);
    if (b == 0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
    end
    z     = 1'b0;
    lat   = 9;
    nbusy = 8;
`ifdef DIVIDER_ZERO_DETECT_EN
    if (b == 0) begin
      z     = 1'b1;
      lat   = 1;
      nbusy = 0;
    end
`endif
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Called on the first negedge after acceptance; returns on the done negedge.
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b,
                           input int inj, input string tag);
    logic [7:0] eq, er, gq, gr;
    logic       ez, gz;
    int         elat, ebusy, first, bc;
    model(a, b, eq, er, ez, elat, ebusy);
    first = 0;
    bc    = 0;
    gq    = '0;
    gr    = '0;
    gz    = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (busy) bc++;
      if (done) begin
        first = c;
        gq    = quotient;
        gr    = remainder;
        gz    = div_zero;
        break;
      end
      if (c == inj) begin
        start    = 1'b1;
        dividend = 8'd1;
        divisor  = 8'd1;
      end else if (inj != 0 && c == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, first, elat);
    chk({tag, "_busy"}, bc, ebusy);
    chk({tag, "_q"}, gq, eq);
    chk({tag, "_r"}, gr, er);
    chk({tag, "_dz"}, gz, ez);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input string tag);
    launch(a, b);
    finish_op(a, b, 0, tag);
  endtask

  initial begin
    logic [7:0] a, b;
    int         dcnt;
    logic [7:0] bl [4];
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_zero, 0);

    @(negedge clk);
    rst_n = 1'b1;
    run(8'd200, 8'd7, "basic");
    @(negedge clk);
    chk("basic_pulse", done, 0);
    chk("basic_idle_busy", busy, 0);
    chk("basic_hold_q", quotient, 28);

    run(8'd255, 8'd1, "b255_1");
    run(8'd5, 8'd9, "b5_9");
    run(8'd0, 8'd3, "b0_3");

    run(8'd100, 8'd10, "b2b_a");
    run(8'd77, 8'd8, "b2b_b");
    @(negedge clk);

    launch(8'd100, 8'd10);
    finish_op(8'd100, 8'd10, 4, "ignore");
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, 10);
    chk("hold_r", remainder, 0);

    run(8'd42, 8'd0, "dz");
    @(negedge clk);
    chk("dz_pulse", done, 0);

    run(8'd100, 8'd10, "pre_rst");
    launch(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("mrst_nodone", dcnt, 0);
    run(8'd9, 8'd3, "after_rst");

    bl[0] = 8'd0;
    bl[1] = 8'd1;
    bl[2] = 8'd128;
    bl[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = (bl[j] == 8'd0) ? 8'd2 : bl[j];
        run(bl[i], b, "edge");
      end
    end

    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      else b = 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
